// File: rtl/dual_port_ram_bank.sv
// True dual-port RAM bank: byte-enabled writes, per-port read-valid, optional output
// register, same-address collision flag, and a post-reset sequencer that zeroes every word.
module dual_port_ram_bank #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = $clog2(DEPTH),
    parameter int unsigned OUT_REG = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  init_done,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [DATA_W/8-1:0]   bea,
    input  logic [ADDR_W-1:0]     addra,
    input  logic [DATA_W-1:0]     dina,
    output logic [DATA_W-1:0]     douta,
    output logic                  vlda,
    input  logic                  enb,
    input  logic                  web,
    input  logic [DATA_W/8-1:0]   beb,
    input  logic [ADDR_W-1:0]     addrb,
    input  logic [DATA_W-1:0]     dinb,
    output logic [DATA_W-1:0]     doutb,
    output logic                  vldb,
    output logic                  collision
);

    localparam int unsigned BE_W = DATA_W / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_we_c;
    logic              rd_a_c, wr_a_c, rd_b_c, wr_b_c;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] rda_q, rdb_q;
    logic              rva_q, rvb_q;

    // Init sequencer: next state and clear-write strobe
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        clr_we_c = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we_c = 1'b1;
                cnt_d    = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            init_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            init_done <= (state_d == READY);
        end
    end

    // Port requests only count once the array has been cleared
    assign rd_a_c = (state_q == READY) && ena && !wea;
    assign wr_a_c = (state_q == READY) && ena &&  wea;
    assign rd_b_c = (state_q == READY) && enb && !web;
    assign wr_b_c = (state_q == READY) && enb &&  web;

    // Storage: B bytes first so A's enabled bytes override on a shared address
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (clr_we_c) begin
                mem[cnt_q] <= '0;
            end else begin
                for (int i = 0; i < BE_W; i++) begin
                    if (wr_b_c && beb[i]) begin
                        mem[addrb][8*i +: 8] <= dinb[8*i +: 8];
                    end
                end
                for (int i = 0; i < BE_W; i++) begin
                    if (wr_a_c && bea[i]) begin
                        mem[addra][8*i +: 8] <= dina[8*i +: 8];
                    end
                end
            end
        end
    end

    // First read stage: old word is captured, so a same-edge write is not seen
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rda_q     <= '0;
            rdb_q     <= '0;
            rva_q     <= 1'b0;
            rvb_q     <= 1'b0;
            collision <= 1'b0;
        end else begin
            rva_q     <= rd_a_c;
            rvb_q     <= rd_b_c;
            collision <= (state_q == READY) && ena && enb && (addra == addrb) && (wea || web);
            if (rd_a_c) begin
                rda_q <= mem[addra];
            end
            if (rd_b_c) begin
                rdb_q <= mem[addrb];
            end
        end
    end

    generate
        if (OUT_REG == 0) begin : g_lat1
            assign douta = rda_q;
            assign doutb = rdb_q;
            assign vlda  = rva_q;
            assign vldb  = rvb_q;
        end else begin : g_lat2
            logic [DATA_W-1:0] douta_q, doutb_q;
            logic              vlda_q, vldb_q;

            // Extra output register stage
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    douta_q <= '0;
                    doutb_q <= '0;
                    vlda_q  <= 1'b0;
                    vldb_q  <= 1'b0;
                end else begin
                    vlda_q <= rva_q;
                    vldb_q <= rvb_q;
                    if (rva_q) begin
                        douta_q <= rda_q;
                    end
                    if (rvb_q) begin
                        doutb_q <= rdb_q;
                    end
                end
            end

            assign douta = douta_q;
            assign doutb = doutb_q;
            assign vlda  = vlda_q;
            assign vldb  = vldb_q;
        end
    endgenerate

endmodule
